// File: rtl/regfile_bypass_pkg.sv
// Shared sizing and helpers for the decode-stage register file.
// Eight registers, 3-bit selects; WIDTH defaults to 16.
package regfile_bypass_pkg;

  localparam int NUM_REGS      = 8;
  localparam int REG_SEL_W     = 3;
  localparam int DEFAULT_WIDTH = 16;

  function automatic logic [NUM_REGS-1:0] sel_decode(input logic [REG_SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_bypass_read_port.sv
// One combinational read port: per-bit 8:1 selection of the stored registers
// with a same-cycle override from the writeback bus. Zero latency, no backpressure.
module regfile_mux8
  import regfile_bypass_pkg::*;
(
  input  logic [NUM_REGS-1:0]  i_in,
  input  logic [REG_SEL_W-1:0] i_sel,
  output logic                 o_out
);
  assign o_out = i_in[i_sel];
endmodule

module regfile_read_port
  import regfile_bypass_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] i_regs,
  input  logic [REG_SEL_W-1:0]           i_sel,
  input  logic                           i_wr_vld,
  input  logic [REG_SEL_W-1:0]           i_wr_sel,
  input  logic [WIDTH-1:0]               i_wr_dat,
  output logic [WIDTH-1:0]               o_rd_dat,
  output logic                           o_hit
);

  logic [WIDTH-1:0] w_store;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_REGS-1:0] w_col;
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign w_col[r] = i_regs[r][b];
    end
    regfile_mux8 u_mux (
      .i_in  (w_col),
      .i_sel (i_sel),
      .o_out (w_store[b])
    );
  end

  assign o_hit    = i_wr_vld & (i_wr_sel == i_sel);
  assign o_rd_dat = o_hit ? i_wr_dat : w_store;

endmodule

// File: rtl/regfile_bypass.sv
// Eight-entry register file with write-to-read bypass and a pending-write scoreboard.
// Reads are combinational; writes/issues land on the rising edge; no backpressure.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_SEL_W-1:0] read1RegSel,
  input  logic [REG_SEL_W-1:0] read2RegSel,
  output logic [WIDTH-1:0]     read1Data,
  output logic [WIDTH-1:0]     read2Data,
  input  logic                 writeEn,
  input  logic [REG_SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]     writeData,
  input  logic                 issueEn,
  input  logic [REG_SEL_W-1:0] issueRegSel,
  output logic                 busy1,
  output logic                 busy2
);

  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]            r_pend;

  logic [NUM_REGS-1:0] w_wr_dec;
  logic [NUM_REGS-1:0] w_is_dec;
  logic                w_byp_vld;
  logic                w_hit1;
  logic                w_hit2;

  assign w_wr_dec  = writeEn ? sel_decode(writeRegSel) : '0;
  assign w_is_dec  = issueEn ? sel_decode(issueRegSel) : '0;
  // Bypass is gated by reset so a write presented during reset never shows on the read ports.
  assign w_byp_vld = writeEn & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wr_dec[r]) begin
          r_regs[r] <= writeData;
        end
      end
    end
  end

  // A newer producer (issue) takes priority over the completing write to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_is_dec | (r_pend & ~w_wr_dec);
    end
  end

  regfile_read_port #(.WIDTH(WIDTH)) u_rd1 (
    .i_regs   (r_regs),
    .i_sel    (read1RegSel),
    .i_wr_vld (w_byp_vld),
    .i_wr_sel (writeRegSel),
    .i_wr_dat (writeData),
    .o_rd_dat (read1Data),
    .o_hit    (w_hit1)
  );

  regfile_read_port #(.WIDTH(WIDTH)) u_rd2 (
    .i_regs   (r_regs),
    .i_sel    (read2RegSel),
    .i_wr_vld (w_byp_vld),
    .i_wr_sel (writeRegSel),
    .i_wr_dat (writeData),
    .o_rd_dat (read2Data),
    .o_hit    (w_hit2)
  );

  assign busy1 = r_pend[read1RegSel] & ~w_hit1;
  assign busy2 = r_pend[read2RegSel] & ~w_hit2;

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed vector table, random traffic against an
// array/flag reference model, and hand-written reset corner sequences.
module tb_regfile_bypass;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   read1RegSel, read2RegSel, writeRegSel, issueRegSel;
  logic [W-1:0] read1Data, read2Data, writeData;
  logic         writeEn, issueEn, busy1, busy2;

  regfile_bypass #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .writeEn     (writeEn),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .busy1       (busy1),
    .busy2       (busy2)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] m_reg [8];
  bit           m_pend[8];

  typedef struct {
    logic       we;
    logic [2:0] wsel;
    logic [15:0] wdat;
    logic       ie;
    logic [2:0] isel;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic       eb1;
    logic       eb2;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic we, logic [2:0] wsel, logic [15:0] wdat, logic ie,
                              logic [2:0] isel, logic [2:0] r1, logic [2:0] r2,
                              logic [15:0] e1, logic [15:0] e2, logic eb1, logic eb2);
    vec_t v;
    v.we = we; v.wsel = wsel; v.wdat = wdat; v.ie = ie; v.isel = isel;
    v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic drive(input logic we, input logic [2:0] wsel, input logic [15:0] wdat,
                       input logic ie, input logic [2:0] isel,
                       input logic [2:0] r1, input logic [2:0] r2);
    writeEn = we; writeRegSel = wsel; writeData = wdat;
    issueEn = ie; issueRegSel = isel;
    read1RegSel = r1; read2RegSel = r2;
  endtask

  // Advance over one rising edge; the model absorbs that edge's write/issue.
  task automatic finish_cycle();
    @(posedge clk);
    if (rst_n) begin
      if (writeEn) begin
        m_reg[writeRegSel]  = writeData;
        m_pend[writeRegSel] = 1'b0;
      end
      if (issueEn) m_pend[issueRegSel] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic model_chk(input string tag);
    logic [W-1:0] e1, e2;
    logic         b1, b2, h1, h2;
    h1 = writeEn && (writeRegSel == read1RegSel);
    h2 = writeEn && (writeRegSel == read2RegSel);
    e1 = h1 ? writeData : m_reg[read1RegSel];
    e2 = h2 ? writeData : m_reg[read2RegSel];
    b1 = m_pend[read1RegSel] && !h1;
    b2 = m_pend[read2RegSel] && !h2;
    chk({tag, "_rd1"}, 32'(read1Data), 32'(e1));
    chk({tag, "_rd2"}, 32'(read2Data), 32'(e2));
    chk({tag, "_busy1"}, 32'(busy1), 32'(b1));
    chk({tag, "_busy2"}, 32'(busy2), 32'(b2));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end

    // Directed table, expectations written from the register-file rules.
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(1, 3'(i), 16'(16'h1111 * i), 0, 0, 3'(i), 3'(i),
                      16'(16'h1111 * i), 16'(16'h1111 * i), 0, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 0, 0, 0, 3'(i), 3'(7 - i),
                      16'(16'h1111 * i), 16'(16'h1111 * (7 - i)), 0, 0));
    vq.push_back(mk(1, 5, 16'h00AA, 0, 0, 4, 4, 16'h4444, 16'h4444, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 5, 4, 16'h00AA, 16'h4444, 0, 0));
    vq.push_back(mk(1, 5, 16'hBEEF, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 5, 4, 16'hBEEF, 16'h4444, 0, 0));
    vq.push_back(mk(0, 0, 0,        1, 2, 2, 3, 16'h2222, 16'h3333, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 2, 2, 16'h2222, 16'h2222, 1, 1));
    vq.push_back(mk(0, 0, 0,        0, 0, 2, 3, 16'h2222, 16'h3333, 1, 0));
    vq.push_back(mk(1, 2, 16'h0042, 0, 0, 2, 3, 16'h0042, 16'h3333, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 2, 2, 16'h0042, 16'h0042, 0, 0));
    vq.push_back(mk(0, 0, 0,        1, 6, 6, 5, 16'h6666, 16'hBEEF, 0, 0));
    vq.push_back(mk(1, 6, 16'h0606, 1, 6, 6, 6, 16'h0606, 16'h0606, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 6, 6, 16'h0606, 16'h0606, 1, 1));
    vq.push_back(mk(1, 6, 16'h6060, 0, 0, 6, 0, 16'h6060, 16'h0000, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 6, 0, 16'h6060, 16'h0000, 0, 0));
    vq.push_back(mk(1, 0, 16'h0F0F, 0, 0, 0, 1, 16'h0F0F, 16'h1111, 0, 0));
    vq.push_back(mk(0, 0, 0,        0, 0, 0, 1, 16'h0F0F, 16'h1111, 0, 0));

    // Reset held with a write and issue presented: outputs stay zero.
    rst_n = 1'b0;
    drive(1, 3, 16'h1234, 1, 3, 3, 5);
    #2;
    chk("rst_rd1", 32'(read1Data), 32'h0);
    chk("rst_rd2", 32'(read2Data), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 3, 3);
    rst_n = 1'b1;
    #2;
    chk("rst_wr_lost", 32'(read1Data), 32'h0);
    chk("rst_iss_lost", 32'(busy1), 32'h0);
    @(negedge clk);

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].wsel, vq[i].wdat, vq[i].ie, vq[i].isel, vq[i].r1, vq[i].r2);
      #2;
      chk($sformatf("tbl%0d_rd1", i), 32'(read1Data), 32'(vq[i].e1));
      chk($sformatf("tbl%0d_rd2", i), 32'(read2Data), 32'(vq[i].e2));
      chk($sformatf("tbl%0d_busy1", i), 32'(busy1), 32'(vq[i].eb1));
      chk($sformatf("tbl%0d_busy2", i), 32'(busy2), 32'(vq[i].eb2));
      finish_cycle();
    end

    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #2;
      model_chk($sformatf("rnd%0d", n));
      finish_cycle();
    end

    // Load a known value, mark every register pending, then pulse reset between edges.
    drive(1, 1, 16'h1357, 0, 0, 1, 1);
    #2;
    model_chk("ld");
    finish_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 3'(i), 1, 7);
      #2;
      model_chk($sformatf("iss%0d", i));
      finish_cycle();
    end
    drive(0, 0, 0, 0, 0, 1, 7);
    #2;
    chk("pend_busy1", 32'(busy1), 32'h1);
    chk("pend_busy2", 32'(busy2), 32'h1);
    chk("pend_rd1", 32'(read1Data), 32'h1357);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", 32'(read1Data), 32'h0);
    chk("arst_rd2", 32'(read2Data), 32'h0);
    chk("arst_busy1", 32'(busy1), 32'h0);
    chk("arst_busy2", 32'(busy2), 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      #2;
      model_chk($sformatf("post%0d", i));
      finish_cycle();
    end
    drive(1, 4, 16'hA5A5, 0, 0, 4, 4);
    #2;
    model_chk("resume_wr");
    finish_cycle();
    drive(0, 0, 0, 0, 0, 4, 1);
    #2;
    model_chk("resume_rd");
    finish_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
